lfsr_range_gen: RTL and testbench

LFSR_RANGE_GEN -- requirements
Module: lfsr_range_gen

---
 rtl/lfsr_pkg.sv | 32 +++
 rtl/lfsr_step.sv | 19 +
 rtl/lfsr_range_gen.sv | 123 ++++++++++++
 tb/tb_lfsr_range_gen.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - FSM state type, default tap masks and mask helper for lfsr_range_gen
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_RESP = 2'd2
  } draw_state_e;

  localparam logic [7:0]  TAPS_8  = 8'hB8;
  localparam logic [15:0] TAPS_16 = 16'hB400;
  localparam logic [31:0] TAPS_32 = 32'hEA000001;
  localparam logic [63:0] TAPS_64 = 64'hD800000000000000;

  function automatic logic [63:0] default_taps(input int w);
    case (w)
      8:       return 64'(TAPS_8);
      16:      return 64'(TAPS_16);
      64:      return TAPS_64;
      default: return 64'(TAPS_32);
    endcase
  endfunction

  // Smallest 2^k-1 that covers v: fill every bit below the highest set bit.
  function automatic logic [63:0] fill_down(input logic [63:0] v);
    logic [63:0] r;
    r = v;
    for (int i = 62; i >= 0; i--) r[i] = r[i] | r[i+1];
    return r;
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// rtl/lfsr_step.sv - combinational multi-step advance of the Fibonacci LFSR
module lfsr_step #(
  parameter int                WIDTH = 32,
  parameter logic [WIDTH-1:0]  TAPS  = '1,
  parameter int                STEPS = 1
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] next_state
);

  logic [WIDTH-1:0] s;

  always_comb begin
    s = state;
    for (int i = 0; i < STEPS; i++) s = {^(s & TAPS), s[WIDTH-1:1]};
    next_state = s;
  end

endmodule

// File: rtl/lfsr_range_gen.sv
// rtl/lfsr_range_gen.sv - LFSR with rejection-sampled range draws over a request/response handshake
// Define LFSR_LOCKUP_EN to reload 1 from an all-zero state and pulse lockup.
module lfsr_range_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(default_taps(WIDTH)),
  parameter int               STEPS     = 1,
  parameter int               OUT_W     = 8,
  parameter int               MAX_TRIES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] state_out,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OUT_W-1:0] req_limit,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OUT_W-1:0] rsp_data,
  output logic             lockup
);

  draw_state_e      fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, stepped;
  logic [OUT_W-1:0] limit_q, limit_d, rsp_q, rsp_d;
  logic [OUT_W-1:0] lim_m1, mask, cand;
  logic [7:0]       tries_q, tries_d;
  logic             advance, zero_hit, accept, last_try, lockup_q;

  lfsr_step #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .STEPS (STEPS)
  ) u_step (
    .state      (state_q),
    .next_state (stepped)
  );

  // A DRAW cycle consumes exactly one advance even when enable is also high.
  assign advance = enable || (fsm_q == ST_DRAW);

`ifdef LFSR_LOCKUP_EN
  assign zero_hit = (state_q == '0);
`else
  assign zero_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WIDTH'(1);
      lockup_q <= 1'b0;
    end else begin
      lockup_q <= zero_hit && !seed_load;
      if (seed_load)     state_q <= (seed == '0) ? WIDTH'(1) : seed;
      else if (zero_hit) state_q <= WIDTH'(1);
      else if (advance)  state_q <= stepped;
    end
  end

  // Candidate comes from the pre-advance state so each DRAW cycle sees a fresh value.
  assign lim_m1   = limit_q - OUT_W'(1);
  assign mask     = (limit_q == '0) ? '1 : OUT_W'(fill_down(64'(lim_m1)));
  assign cand     = state_q[OUT_W-1:0] & mask;
  assign accept   = (limit_q == '0) || (cand < limit_q);
  assign last_try = (tries_q == 8'(MAX_TRIES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= ST_IDLE;
      limit_q <= '0;
      tries_q <= '0;
      rsp_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      limit_q <= limit_d;
      tries_q <= tries_d;
      rsp_q   <= rsp_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    limit_d = limit_q;
    tries_d = tries_q;
    rsp_d   = rsp_q;
    case (fsm_q)
      ST_IDLE: begin
        if (req_valid) begin
          limit_d = req_limit;
          tries_d = '0;
          fsm_d   = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (accept) begin
          rsp_d = cand;
          fsm_d = ST_RESP;
        end else if (last_try) begin
          // Out of attempts: fold the rejected candidate into range.
          rsp_d = cand - limit_q;
          fsm_d = ST_RESP;
        end else begin
          tries_d = tries_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) fsm_d = ST_IDLE;
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  assign state_out = state_q;
  assign req_ready = (fsm_q == ST_IDLE);
  assign rsp_valid = (fsm_q == ST_RESP);
  assign rsp_data  = rsp_q;
  assign lockup    = lockup_q;

endmodule

// File: tb/tb_lfsr_range_gen.sv
// tb/tb_lfsr_range_gen.sv - scoreboard bench for lfsr_range_gen (default, MAX_TRIES=1, TAPS=0 instances)
module tb_lfsr_range_gen;

  localparam logic [31:0] TAPS_DEF = 32'hEA000001;
  localparam int          N_REQ    = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, seed_load, req_valid, rsp_ready;
  logic [31:0] seed;
  logic [7:0]  req_limit;
  logic [31:0] state_a, state_b, state_z;
  logic        ready_a, ready_b, ready_z, valid_a, valid_b, valid_z;
  logic        lock_a, lock_b, lock_z;
  logic [7:0]  data_a, data_b, data_z;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];
  logic [31:0] m_state;
  bit          seen[6];

  lfsr_range_gen u_dut (
    .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load), .seed(seed),
    .state_out(state_a), .req_valid(req_valid), .req_ready(ready_a), .req_limit(req_limit),
    .rsp_valid(valid_a), .rsp_ready(rsp_ready), .rsp_data(data_a), .lockup(lock_a)
  );

  lfsr_range_gen #(.MAX_TRIES(1)) u_mt1 (
    .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load), .seed(seed),
    .state_out(state_b), .req_valid(req_valid), .req_ready(ready_b), .req_limit(req_limit),
    .rsp_valid(valid_b), .rsp_ready(rsp_ready), .rsp_data(data_b), .lockup(lock_b)
  );

  lfsr_range_gen #(.TAPS(32'h0)) u_zero (
    .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load), .seed(seed),
    .state_out(state_z), .req_valid(req_valid), .req_ready(ready_z), .req_limit(req_limit),
    .rsp_valid(valid_z), .rsp_ready(rsp_ready), .rsp_data(data_z), .lockup(lock_z)
  );

  function automatic logic [31:0] mstep(input logic [31:0] s, input logic [31:0] taps);
    return {^(s & taps), s[31:1]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; seed_load = 1'b0; seed = '0;
    req_valid = 1'b0; req_limit = '0; rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_state = 32'h1;
  endtask

  task automatic load_seed(input logic [31:0] v);
    seed_load = 1'b1; seed = v;
    @(negedge clk);
    seed_load = 1'b0;
    m_state = (v == 0) ? 32'h1 : v;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (state_a !== 32'h1) begin n_err++; $display("FAIL reset_state: got %h want 00000001", state_a); end
    n_vec++; if (ready_a !== 1'b1)  begin n_err++; $display("FAIL reset_req_ready: got %b want 1", ready_a); end
    n_vec++; if (valid_a !== 1'b0)  begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", valid_a); end
    n_vec++; if (data_a !== 8'h0)   begin n_err++; $display("FAIL reset_rsp_data: got %h want 00", data_a); end
    n_vec++; if (lock_a !== 1'b0)   begin n_err++; $display("FAIL reset_lockup: got %b want 0", lock_a); end
  endtask

  task automatic test_step_sequence();
    logic [31:0] e, s;
    do_reset();
    exp_q.push_back(32'h00000001);
    exp_q.push_back(32'h80000000);
    exp_q.push_back(32'hC0000000);
    s = 32'hC0000000;
    for (int i = 0; i < 6; i++) begin s = mstep(s, TAPS_DEF); exp_q.push_back(s); end
    enable = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++; if (state_a !== e) begin n_err++; $display("FAIL step_seq: got %h want %h", state_a, e); end
      if (exp_q.size() == 0) enable = 1'b0;
      @(negedge clk);
    end
    n_vec++; if (state_a !== s) begin n_err++; $display("FAIL step_hold: got %h want %h", state_a, s); end
  endtask

  task automatic test_seed_load();
    logic [31:0] e;
    seed_load = 1'b1; seed = 32'h0; enable = 1'b1;
    exp_q.push_back(32'h1);
    @(negedge clk);
    e = exp_q.pop_front();
    n_vec++; if (state_a !== e) begin n_err++; $display("FAIL seed_zero: got %h want %h", state_a, e); end
    seed = 32'h12345678;
    exp_q.push_back(32'h12345678);
    @(negedge clk);
    seed_load = 1'b0; enable = 1'b0;
    e = exp_q.pop_front();
    n_vec++; if (state_a !== e) begin n_err++; $display("FAIL seed_value: got %h want %h", state_a, e); end
    @(negedge clk);
    n_vec++; if (state_a !== e) begin n_err++; $display("FAIL seed_idle_hold: got %h want %h", state_a, e); end
  endtask

  task automatic test_limit_one();
    logic [31:0] e;
    do_reset();
    req_valid = 1'b1; req_limit = 8'd1; rsp_ready = 1'b0;
    exp_q.push_back(32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    n_vec++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL lim1_early_valid: got %b want 0", valid_a); end
    @(negedge clk);
    e = exp_q.pop_front();
    n_vec++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL lim1_valid: got %b want 1", valid_a); end
    n_vec++; if (data_a !== e[7:0]) begin n_err++; $display("FAIL lim1_data: got %h want %h", data_a, e[7:0]); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (valid_a !== 1'b1 || data_a !== e[7:0]) begin
        n_err++; $display("FAIL lim1_hold: got valid %b data %h want valid 1 data %h", valid_a, data_a, e[7:0]);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    n_vec++; if (valid_a !== 1'b0 || ready_a !== 1'b1) begin
      n_err++; $display("FAIL lim1_release: got valid %b ready %b want 0 1", valid_a, ready_a);
    end
  endtask

  task automatic do_draw(input logic [7:0] lim);
    logic [31:0] s, e;
    int li, mask, cand, res, tries, lat, el;
    logic [7:0] got;
    bit hs;
    li = int'(lim);
    mask = 255;
    if (li != 0) begin mask = 0; while (mask < li - 1) mask = mask * 2 + 1; end
    s = m_state; res = -1; tries = 0;
    while (res < 0) begin
      cand = int'(s[7:0]) & mask;
      s = mstep(s, TAPS_DEF);
      tries++;
      if (li == 0 || cand < li) res = cand;
      else if (tries == 16) res = cand - li;
    end
    m_state = s;
    exp_q.push_back(32'(res));
    lat_q.push_back(tries + 1);

    lat = 0;
    while (!ready_a && lat < 8) begin @(negedge clk); lat++; end
    n_vec++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL draw_req_ready: got %b want 1", ready_a); end
    req_valid = 1'b1; req_limit = lim;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!valid_a && lat < 40) begin @(negedge clk); lat++; end
    e = exp_q.pop_front();
    el = lat_q.pop_front();
    n_vec++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL draw_timeout: lim %0d got valid %b want 1", li, valid_a); end
    n_vec++; if (data_a !== e[7:0]) begin n_err++; $display("FAIL draw_data: lim %0d got %h want %h", li, data_a, e[7:0]); end
    n_vec++; if (lat != el || lat > 17) begin n_err++; $display("FAIL draw_latency: lim %0d got %0d want %0d", li, lat, el); end
    if (li != 0) begin
      n_vec++; if (int'(data_a) >= li) begin n_err++; $display("FAIL draw_range: got %0d want < %0d", data_a, li); end
    end
    if (li == 6 && data_a < 8'd6) seen[data_a] = 1'b1;

    got = data_a; hs = 1'b0;
    for (int i = 0; i < 32 && !hs; i++) begin
      rsp_ready = (i == 31) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      hs = rsp_ready;
      if (!hs) begin
        n_vec++;
        if (valid_a !== 1'b1 || data_a !== got) begin
          n_err++; $display("FAIL draw_stable: got valid %b data %h want 1 %h", valid_a, data_a, got);
        end
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_limits();
    logic [7:0] lims[9];
    lims = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd5, 8'd128, 8'd129, 8'd200, 8'd255};
    do_reset();
    load_seed(32'hACE1_2468);
    for (int k = 0; k < 9; k++)
      for (int j = 0; j < 4; j++) do_draw(lims[k]);
  endtask

  task automatic test_random_six();
    do_reset();
    load_seed($urandom | 32'h1);
    for (int i = 0; i < 6; i++) seen[i] = 1'b0;
    for (int i = 0; i < N_REQ; i++) do_draw(8'd6);
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (!seen[i]) begin n_err++; $display("FAIL six_coverage: value %0d got unseen want seen", i); end
    end
  endtask

  task automatic test_fallback();
    logic [31:0] e;
    do_reset();
    load_seed(32'h00000007);
    req_valid = 1'b1; req_limit = 8'd5;
    exp_q.push_back(32'd2);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_vec++; if (valid_b !== 1'b1) begin n_err++; $display("FAIL fallback_valid: got %b want 1", valid_b); end
    n_vec++; if (data_b !== e[7:0]) begin n_err++; $display("FAIL fallback_data: got %h want %h", data_b, e[7:0]); end
    rsp_ready = 1'b1;
    repeat (20) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_lockup();
    logic [31:0] e;
    int el;
    do_reset();
`ifdef LFSR_LOCKUP_EN
    exp_q = '{32'h1, 32'h0, 32'h1, 32'h0, 32'h1};
    lat_q = '{0, 0, 1, 0, 1};
`else
    exp_q = '{32'h1, 32'h0, 32'h0, 32'h0, 32'h0};
    lat_q = '{0, 0, 0, 0, 0};
`endif
    enable = 1'b1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      el = lat_q.pop_front();
      n_vec++; if (state_z !== e) begin n_err++; $display("FAIL lockup_state: got %h want %h", state_z, e); end
      n_vec++; if (lock_z !== 1'(el)) begin n_err++; $display("FAIL lockup_pulse: got %b want %0d", lock_z, el); end
      @(negedge clk);
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    load_seed(32'h000000A5);
    req_valid = 1'b1; req_limit = 8'd0;
    exp_q.push_back(32'hA5);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (valid_a !== 1'b1 || data_a !== exp_q.pop_front()) begin
      n_err++; $display("FAIL flight_resp: got valid %b data %h want 1 a5", valid_a, data_a);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++; if (valid_a !== 1'b0 || ready_a !== 1'b1) begin
      n_err++; $display("FAIL flight_discard: got valid %b ready %b want 0 1", valid_a, ready_a);
    end
    n_vec++; if (data_a !== 8'h0 || state_a !== 32'h1) begin
      n_err++; $display("FAIL flight_clear: got data %h state %h want 00 00000001", data_a, state_a);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; seed_load = 1'b0; seed = '0;
    req_valid = 1'b0; req_limit = '0; rsp_ready = 1'b0;
    test_reset();
    test_step_sequence();
    test_seed_load();
    test_limit_one();
    test_limits();
    test_random_six();
    test_fallback();
    test_lockup();
    test_reset_in_flight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
